mc_ctrl: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS control decoder. Sequences each instruction through IF/ID/EX/MEM/WB states.
- Drives the same datapath select signals (RegDst, ALUSrc, ALUCtrl, DatatoReg, PC_sel, ExtOp, IsJump) plus per-state write enables.
- Uses a ready/request handshake toward a shared instruction/data memory with variable latency.
- Sits between the IR (opcode/func fields) and the multi-cycle datapath.

---
 rtl/mc_ctrl_pkg.sv | 71 +++++++
 rtl/mc_ctrl_decode.sv | 66 ++++++
 rtl/mc_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl shared constants: FSM states, instruction classes,
// datapath mux encodings and MIPS opcode/funct codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX     = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWR  = 4'd5,
    S_WB_ALU = 4'd6,
    S_WB_MEM = 4'd7,
    S_BR     = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE_ALU = 3'd0,
    C_ITYPE_ALU = 3'd1,
    C_LOAD      = 3'd2,
    C_STORE     = 3'd3,
    C_BRANCH    = 3'd4,
    C_JUMP      = 3'd5,
    C_ILLEGAL   = 3'd6
  } iclass_t;

  localparam logic [4:0] ALUOp_ADDU = 5'd0;
  localparam logic [4:0] ALUOp_ADD  = 5'd1;
  localparam logic [4:0] ALUOp_SUBU = 5'd2;
  localparam logic [4:0] ALUOp_SUB  = 5'd3;
  localparam logic [4:0] ALUOp_OR   = 5'd4;
  localparam logic [4:0] ALUOp_SLT  = 5'd5;
  localparam logic [4:0] ALUOp_LUI  = 5'd6;
  localparam logic [4:0] ALUOp_EQL  = 5'd7;
  localparam logic [4:0] ALUOp_BNE  = 5'd8;

  localparam logic [1:0] REG_MUX_SEL_RT = 2'd0;
  localparam logic [1:0] REG_MUX_SEL_RD = 2'd1;

  localparam logic [1:0] DR_MUX_SEL_ALU = 2'd0;
  localparam logic [1:0] DR_MUX_SEL_MEM = 2'd1;

  localparam logic [1:0] PC_MUX_SEL_NEWPC  = 2'd0;
  localparam logic [1:0] PC_MUX_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_MUX_SEL_JUMP   = 2'd2;

  // The constant-4 increment shares the EXT leg of the B-operand mux.
  localparam logic ALU_SRC_MUX_SEL_REG = 1'b0;
  localparam logic ALU_SRC_MUX_SEL_EXT = 1'b1;
  localparam logic ALU_SRC_MUX_SEL_PC4 = 1'b1;

  localparam logic EXT_ZERO   = 1'b0;
  localparam logic EXT_SIGNED = 1'b1;

  localparam logic [5:0] INSTR_RTYPE_OP = 6'b000000;
  localparam logic [5:0] INSTR_J_OP     = 6'b000010;
  localparam logic [5:0] INSTR_BEQ_OP   = 6'b000100;
  localparam logic [5:0] INSTR_BNE_OP   = 6'b000101;
  localparam logic [5:0] INSTR_SLTI_OP  = 6'b001010;
  localparam logic [5:0] INSTR_ORI_OP   = 6'b001101;
  localparam logic [5:0] INSTR_LUI_OP   = 6'b001111;
  localparam logic [5:0] INSTR_LW_OP    = 6'b100011;
  localparam logic [5:0] INSTR_SW_OP    = 6'b101011;

  localparam logic [5:0] INSTR_ADD_FUNCT  = 6'b100000;
  localparam logic [5:0] INSTR_ADDU_FUNCT = 6'b100001;
  localparam logic [5:0] INSTR_SUB_FUNCT  = 6'b100010;
  localparam logic [5:0] INSTR_SUBU_FUNCT = 6'b100011;
  localparam logic [5:0] INSTR_SLT_FUNCT  = 6'b101010;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational opcode/func classifier and
// EX-stage ALU operation, operand source and extension select.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_func,
  output iclass_t    o_cls,
  output logic [4:0] o_alu,
  output logic       o_alusrc,
  output logic       o_extop
);

  always_comb begin
    o_cls    = C_ILLEGAL;
    o_alu    = ALUOp_ADDU;
    o_alusrc = ALU_SRC_MUX_SEL_REG;
    o_extop  = EXT_ZERO;
    case (i_opcode)
      INSTR_RTYPE_OP: begin
        o_cls = C_RTYPE_ALU;
        case (i_func)
          INSTR_ADD_FUNCT:  o_alu = ALUOp_ADD;
          INSTR_ADDU_FUNCT: o_alu = ALUOp_ADDU;
          INSTR_SUB_FUNCT:  o_alu = ALUOp_SUB;
          INSTR_SUBU_FUNCT: o_alu = ALUOp_SUBU;
          INSTR_SLT_FUNCT:  o_alu = ALUOp_SLT;
          default:          o_cls = C_ILLEGAL;
        endcase
      end
      INSTR_ORI_OP: begin
        o_cls    = C_ITYPE_ALU;
        o_alu    = ALUOp_OR;
        o_alusrc = ALU_SRC_MUX_SEL_EXT;
      end
      INSTR_LUI_OP: begin
        o_cls    = C_ITYPE_ALU;
        o_alu    = ALUOp_LUI;
        o_alusrc = ALU_SRC_MUX_SEL_EXT;
      end
      INSTR_SLTI_OP: begin
        o_cls    = C_ITYPE_ALU;
        o_alu    = ALUOp_SLT;
        o_alusrc = ALU_SRC_MUX_SEL_EXT;
        o_extop  = EXT_SIGNED;
      end
      INSTR_LW_OP, INSTR_SW_OP: begin
        o_cls    = (i_opcode == INSTR_LW_OP) ? C_LOAD : C_STORE;
        o_alu    = ALUOp_ADD;
        o_alusrc = ALU_SRC_MUX_SEL_EXT;
        o_extop  = EXT_SIGNED;
      end
      INSTR_BEQ_OP: begin
        o_cls = C_BRANCH;
        o_alu = ALUOp_EQL;
      end
      INSTR_BNE_OP: begin
        o_cls = C_BRANCH;
        o_alu = ALUOp_BNE;
      end
      INSTR_J_OP: o_cls = C_JUMP;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM with memory handshake.
// Optional perf counters under `define MC_CTRL_PERF_CNT_EN.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W   = 5,
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 32
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic [1:0]           PC_sel,
  output logic [1:0]           IsJump,
  output logic [1:0]           RegDst,
  output logic                 RegWrite,
  output logic [1:0]           DatatoReg,
  output logic                 ALUSrc,
  output logic                 ExtOp,
  output logic [ALUCTRL_W-1:0] ALUCtrl,
  output logic                 illegal,
  output logic                 mem_err
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     cyc_cnt,
  output logic [CNT_W-1:0]     instr_cnt
`endif
);

  state_t      r_state, w_next;
  iclass_t     w_cls;
  logic [4:0]  w_dec_alu;
  logic        w_dec_src, w_dec_ext;
  logic [15:0] r_to_cnt;
  logic        r_mem_err;
  logic        w_req_st, w_to_hit, w_retire;

  logic       w_req, w_iord, w_rd, w_wr, w_irw, w_pcw, w_pcwc;
  logic       w_rw, w_src, w_ext, w_ill;
  logic [1:0] w_pcsel, w_jmp, w_dst, w_dr;
  logic [4:0] w_alu;

  mc_ctrl_decode u_dec (
    .i_opcode (opcode),
    .i_func   (func),
    .o_cls    (w_cls),
    .o_alu    (w_dec_alu),
    .o_alusrc (w_dec_src),
    .o_extop  (w_dec_ext)
  );

  assign w_req_st = (r_state == S_IF) || (r_state == S_MEMRD) ||
                    (r_state == S_MEMWR);
  assign w_to_hit = (MEM_TIMEOUT != 0) && w_req_st && !mem_ready &&
                    (int'(r_to_cnt) == MEM_TIMEOUT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_mem_err <= 1'b0;
    end else if (w_to_hit) begin
      r_to_cnt  <= '0;
      r_mem_err <= 1'b1;
    end else if (MEM_TIMEOUT != 0 && w_req_st && !mem_ready) begin
      r_to_cnt  <= r_to_cnt + 16'd1;
    end else begin
      r_to_cnt  <= '0;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_req    = 1'b0;
    w_iord   = 1'b0;
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    w_irw    = 1'b0;
    w_pcw    = 1'b0;
    w_pcwc   = 1'b0;
    w_pcsel  = PC_MUX_SEL_NEWPC;
    w_jmp    = 2'd0;
    w_dst    = REG_MUX_SEL_RT;
    w_rw     = 1'b0;
    w_dr     = DR_MUX_SEL_ALU;
    w_src    = ALU_SRC_MUX_SEL_REG;
    w_ext    = EXT_ZERO;
    w_alu    = ALUOp_ADDU;
    w_ill    = 1'b0;
    case (r_state)
      S_IF: begin
        w_req = 1'b1;
        w_rd  = 1'b1;
        w_src = ALU_SRC_MUX_SEL_PC4;
        if (mem_ready) begin
          w_irw  = 1'b1;
          w_pcw  = 1'b1;
          w_next = S_ID;
        end
      end
      S_ID: begin
        unique case (w_cls)
          C_JUMP: begin
            w_pcw    = 1'b1;
            w_pcsel  = PC_MUX_SEL_JUMP;
            w_jmp    = 2'd1;
            w_next   = S_IF;
            w_retire = 1'b1;
          end
          C_RTYPE_ALU, C_ITYPE_ALU: w_next = S_EX;
          C_LOAD, C_STORE:          w_next = S_MEMADR;
          C_BRANCH:                 w_next = S_BR;
          default: begin
            w_ill  = 1'b1;
            w_next = S_IF;
          end
        endcase
      end
      S_EX: begin
        w_alu  = w_dec_alu;
        w_src  = w_dec_src;
        w_ext  = w_dec_ext;
        w_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        w_rw     = 1'b1;
        w_dst    = (w_cls == C_RTYPE_ALU) ? REG_MUX_SEL_RD
                                          : REG_MUX_SEL_RT;
        w_next   = S_IF;
        w_retire = 1'b1;
      end
      S_MEMADR: begin
        w_alu  = ALUOp_ADD;
        w_src  = ALU_SRC_MUX_SEL_EXT;
        w_ext  = EXT_SIGNED;
        w_next = (w_cls == C_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_req  = 1'b1;
        w_rd   = 1'b1;
        w_iord = 1'b1;
        if (mem_ready) w_next = S_WB_MEM;
      end
      S_MEMWR: begin
        w_req  = 1'b1;
        w_wr   = 1'b1;
        w_iord = 1'b1;
        if (mem_ready) begin
          w_next   = S_IF;
          w_retire = 1'b1;
        end
      end
      S_WB_MEM: begin
        w_rw     = 1'b1;
        w_dr     = DR_MUX_SEL_MEM;
        w_next   = S_IF;
        w_retire = 1'b1;
      end
      S_BR: begin
        w_alu    = w_dec_alu;
        w_pcwc   = 1'b1;
        w_pcsel  = PC_MUX_SEL_BRANCH;
        w_next   = S_IF;
        w_retire = 1'b1;
      end
      default: w_next = S_IF;
    endcase
    // Abandon the stalled request; no retire, no IR/PC update.
    if (w_to_hit) begin
      w_next   = S_IF;
      w_retire = 1'b0;
      w_irw    = 1'b0;
      w_pcw    = 1'b0;
    end
  end

  assign mem_req     = w_req  & ~rst;
  assign IorD        = w_iord & ~rst;
  assign MemRead     = w_rd   & ~rst;
  assign MemWrite    = w_wr   & ~rst;
  assign IRWrite     = w_irw  & ~rst;
  assign PCWrite     = w_pcw  & ~rst;
  assign PCWriteCond = w_pcwc & ~rst;
  assign RegWrite    = w_rw   & ~rst;
  assign ALUSrc      = w_src  & ~rst;
  assign ExtOp       = w_ext  & ~rst;
  assign illegal     = w_ill  & ~rst;
  assign PC_sel      = rst ? 2'd0 : w_pcsel;
  assign IsJump      = rst ? 2'd0 : w_jmp;
  assign RegDst      = rst ? 2'd0 : w_dst;
  assign DatatoReg   = rst ? 2'd0 : w_dr;
  assign ALUCtrl     = rst ? '0 : ALUCTRL_W'(w_alu);
  assign mem_err     = r_mem_err & ~rst;

`ifdef MC_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_cyc, r_instr;
  logic             w_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc   <= '0;
      r_instr <= '0;
    end else begin
      r_cyc <= r_cyc + CNT_W'(1);
      if (w_retire) r_instr <= r_instr + CNT_W'(1);
    end
  end

  assign cyc_cnt   = r_cyc;
  assign instr_cnt = r_instr;
  assign w_unused  = zero;
`else
  logic w_unused;
  assign w_unused = ^{zero, w_retire};
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed-vector bench for the mc_ctrl FSM,
// built with MEM_TIMEOUT=4 to cover the timeout path.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode, func;
  logic       zero, mem_ready;
  logic       mem_req, IorD, MemRead, MemWrite, IRWrite;
  logic       PCWrite, PCWriteCond, RegWrite, ALUSrc, ExtOp;
  logic       illegal, mem_err;
  logic [1:0] PC_sel, IsJump, RegDst, DatatoReg;
  logic [4:0] ALUCtrl;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_ctrl #(
    .ALUCTRL_W   (5),
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .func        (func),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PC_sel      (PC_sel),
    .IsJump      (IsJump),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .DatatoReg   (DatatoReg),
    .ALUSrc      (ALUSrc),
    .ExtOp       (ExtOp),
    .ALUCtrl     (ALUCtrl),
    .illegal     (illegal),
    .mem_err     (mem_err)
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    .cyc_cnt     (cyc_cnt),
    .instr_cnt   (instr_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy);
    @(negedge clk);
    opcode    = op;
    func      = fn;
    mem_ready = rdy;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    opcode    = 6'd0;
    func      = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", {mem_req, IorD, MemRead, MemWrite, IRWrite,
                     PCWrite, PCWriteCond, PC_sel, IsJump, RegDst,
                     RegWrite, DatatoReg, ALUSrc, ExtOp, ALUCtrl,
                     illegal}, 32'd0);
    chk("rst_err", mem_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // addu: IF ID EX WB_ALU
    cyc(INSTR_RTYPE_OP, INSTR_ADDU_FUNCT, 1'b1);
    chk("if_req", mem_req, 1);
    chk("if_rd", MemRead, 1);
    chk("if_ir", IRWrite, 1);
    chk("if_alu", ALUCtrl, ALUOp_ADDU);
    chk("if_src", ALUSrc, 1);
    cyc(INSTR_RTYPE_OP, INSTR_ADDU_FUNCT, 1'b1);
    chk("id_req", mem_req, 0);
    chk("id_rw", RegWrite, 0);
    cyc(INSTR_RTYPE_OP, INSTR_ADDU_FUNCT, 1'b1);
    chk("ex_alu", ALUCtrl, ALUOp_ADDU);
    chk("ex_src", ALUSrc, 0);
    chk("ex_rw", RegWrite, 0);
    cyc(INSTR_RTYPE_OP, INSTR_ADDU_FUNCT, 1'b1);
    chk("wb_rw", RegWrite, 1);
    chk("wb_dst", RegDst, REG_MUX_SEL_RD);
    chk("wb_dr", DatatoReg, DR_MUX_SEL_ALU);

    // lw with two wait cycles in MEMRD
    cyc(INSTR_LW_OP, 6'd0, 1'b1);
    chk("lw_if", IRWrite, 1);
    cyc(INSTR_LW_OP, 6'd0, 1'b1);
    cyc(INSTR_LW_OP, 6'd0, 1'b1);
    chk("ma_alu", ALUCtrl, ALUOp_ADD);
    chk("ma_src", ALUSrc, 1);
    chk("ma_ext", ExtOp, EXT_SIGNED);
    for (int i = 0; i < 3; i++) begin
      cyc(INSTR_LW_OP, 6'd0, (i == 2));
      chk("lw_rd", MemRead, 1);
      chk("lw_iord", IorD, 1);
      chk("lw_wr", MemWrite, 0);
    end
    cyc(INSTR_LW_OP, 6'd0, 1'b1);
    chk("lwb_rw", RegWrite, 1);
    chk("lwb_dr", DatatoReg, DR_MUX_SEL_MEM);
    chk("lwb_dst", RegDst, REG_MUX_SEL_RT);
    chk("lwb_req", mem_req, 0);

    // beq: IF ID BR, back to IF in cycle 4
    cyc(INSTR_BEQ_OP, 6'd0, 1'b1);
    chk("beq_if", IorD, 0);
    cyc(INSTR_BEQ_OP, 6'd0, 1'b1);
    cyc(INSTR_BEQ_OP, 6'd0, 1'b1);
    chk("br_pwc", PCWriteCond, 1);
    chk("br_alu", ALUCtrl, ALUOp_EQL);
    chk("br_sel", PC_sel, PC_MUX_SEL_BRANCH);

    // j: IF ID
    cyc(INSTR_J_OP, 6'd0, 1'b1);
    chk("beq_next", mem_req, 1);
    cyc(INSTR_J_OP, 6'd0, 1'b1);
    chk("j_pcw", PCWrite, 1);
    chk("j_jmp", IsJump, 1);
    chk("j_sel", PC_sel, PC_MUX_SEL_JUMP);

    // illegal opcode, then R-type with unknown func
    cyc(6'h3f, 6'd0, 1'b1);
    chk("j_next", mem_req, 1);
    cyc(6'h3f, 6'd0, 1'b1);
    chk("ill_p", illegal, 1);
    chk("ill_rw", RegWrite, 0);
    chk("ill_mw", MemWrite, 0);
    chk("ill_pcw", PCWrite, 0);
    cyc(INSTR_RTYPE_OP, 6'd0, 1'b1);
    chk("ill_end", illegal, 0);
    chk("ill_next", mem_req, 1);
    cyc(INSTR_RTYPE_OP, 6'd0, 1'b1);
    chk("fn_ill", illegal, 1);

    // ori and slti EX values
    cyc(INSTR_ORI_OP, 6'd0, 1'b1);
    cyc(INSTR_ORI_OP, 6'd0, 1'b1);
    cyc(INSTR_ORI_OP, 6'd0, 1'b1);
    chk("ori_alu", ALUCtrl, ALUOp_OR);
    chk("ori_src", ALUSrc, ALU_SRC_MUX_SEL_EXT);
    chk("ori_ext", ExtOp, EXT_ZERO);
    cyc(INSTR_ORI_OP, 6'd0, 1'b1);
    chk("ori_dst", RegDst, REG_MUX_SEL_RT);
    chk("ori_rw", RegWrite, 1);
    cyc(INSTR_SLTI_OP, 6'd0, 1'b1);
    cyc(INSTR_SLTI_OP, 6'd0, 1'b1);
    cyc(INSTR_SLTI_OP, 6'd0, 1'b1);
    chk("slti_alu", ALUCtrl, ALUOp_SLT);
    chk("slti_ext", ExtOp, EXT_SIGNED);
    cyc(INSTR_SLTI_OP, 6'd0, 1'b1);

    // fetch timeout after 4 wait cycles
    for (int i = 0; i < 4; i++) begin
      cyc(INSTR_SW_OP, 6'd0, 1'b0);
      chk("to_ir", IRWrite, 0);
      chk("to_err0", mem_err, 0);
    end
    cyc(INSTR_SW_OP, 6'd0, 1'b0);
    chk("to_err", mem_err, 1);
    chk("to_ir2", IRWrite, 0);
    chk("to_req", mem_req, 1);

    // sw, reset asserted in MEMWR
    cyc(INSTR_SW_OP, 6'd0, 1'b1);
    chk("sw_if", IRWrite, 1);
    cyc(INSTR_SW_OP, 6'd0, 1'b1);
    cyc(INSTR_SW_OP, 6'd0, 1'b1);
    cyc(INSTR_SW_OP, 6'd0, 1'b0);
    chk("sw_mw", MemWrite, 1);
    chk("sw_mr", MemRead, 0);
    rst = 1'b1;
    #1;
    chk("rst_mw", MemWrite, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_err2", mem_err, 0);
`ifdef MC_CTRL_PERF_CNT_EN
    chk("rst_cyc", cyc_cnt, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

`ifdef MC_CTRL_PERF_CNT_EN
    for (int i = 0; i < 4; i++)
      cyc(INSTR_RTYPE_OP, INSTR_ADDU_FUNCT, 1'b1);
    for (int i = 0; i < 4; i++)
      cyc(INSTR_SW_OP, 6'd0, 1'b1);
    for (int i = 0; i < 2; i++)
      cyc(INSTR_J_OP, 6'd0, 1'b1);
    cyc(INSTR_RTYPE_OP, INSTR_ADDU_FUNCT, 1'b0);
    chk("perf_instr", instr_cnt, 3);
    chk("perf_cyc", cyc_cnt, 10);
`else
    cyc(INSTR_RTYPE_OP, INSTR_ADDU_FUNCT, 1'b1);
    chk("post_rst_if", mem_req, 1);
    chk("post_rst_err", mem_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
